decoder_scan_n: RTL and testbench

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with enable and a self-timed scan mode. In direct mode it decodes `din` into a registered one-hot `dout`. In scan mode an internal sequencer walks `dout` through every output in turn, holding each for a programmable dwell. It drives multiplexer selects and multiplexed-display digit enables in the datapath, and supersedes the fixed 2-to-4 gate-level decoder wherever registered or scanned selects are needed.

---
 rtl/decoder_scan_n.sv | 188 ++++++++++++++++++
 tb/tb_decoder_scan_n.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_n.sv
// ---------------------------------------------------------------------------
// decoder_scan_n
//
// Registered SEL_W-to-2**SEL_W one-hot decoder with an enable and a
// self-timed scan mode.
//
//   Direct mode (d_mode = 0): dout is the registered one-hot of din.
//   Scan mode   (d_mode = 1): an internal sequencer walks dout through every
//                             output in turn. Each output is held for DWELL
//                             cycles. scan_wrap pulses on the first cycle of
//                             index 0 of every scan period.
//
// Parameters
//   SEL_W  select width (1..6). Output count N = 2**SEL_W.
//   DWELL  clock cycles each output is held in scan mode (1..65535).
//
// Ports
//   clk        in   1      single rising-edge clock
//   rst        in   1      synchronous active-high reset
//   d_en       in   1      decoder enable; low forces all outputs to zero
//   d_mode     in   1      0 = direct decode, 1 = scan
//   din        in   SEL_W  select value in direct mode (ignored in scan)
//   dout       out  N      registered one-hot (or all-zero) select
//   dout_idx   out  SEL_W  registered index of the active (or next) output
//   scan_wrap  out  1      one-cycle pulse at the start of each scan period
//
// Optional feature
//   DECODER_SCAN_BLANK_EN  When defined, scan mode is break-before-make: one
//                          all-zero cycle is inserted after each index's dwell,
//                          with dout_idx already showing the next index.
// ---------------------------------------------------------------------------
module decoder_scan_n #(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    d_en,
    input  logic                    d_mode,
    input  logic [SEL_W-1:0]        din,
    output logic [(2**SEL_W)-1:0]   dout,
    output logic [SEL_W-1:0]        dout_idx,
    output logic                    scan_wrap
);

    localparam int N = 2 ** SEL_W;

    // The dwell counter is wide enough for the largest legal DWELL.
    localparam int          CNT_W   = 16;
    localparam logic [CNT_W-1:0] DWELL_C = CNT_W'(DWELL);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [SEL_W-1:0] IDX_ONE = SEL_W'(1);
    localparam logic [N-1:0]     ONE_N   = N'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       dout_q, dout_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               wrap_q, wrap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef DECODER_SCAN_BLANK_EN
    logic               blank_q, blank_d;
`endif

    function automatic logic [N-1:0] oneHot(input logic [SEL_W-1:0] sel);
        return ONE_N << sel;
    endfunction

    // Next-state and next-output evaluation. The target state is chosen from
    // the inputs alone every cycle; the outputs are then derived from that
    // target state together with the current registered state, so that
    // entering SCAN can be told apart from staying in it.
    always_comb begin
        state_d = state_q;
        dout_d  = '0;
        idx_d   = '0;
        wrap_d  = 1'b0;
        cnt_d   = '0;
`ifdef DECODER_SCAN_BLANK_EN
        blank_d = 1'b0;
`endif

        if (!d_en) begin
            state_d = IDLE;
        end else if (!d_mode) begin
            state_d = DIRECT;
        end else begin
            state_d = SCAN;
        end

        case (state_d)
            IDLE: begin
                // Everything already defaults to zero.
            end

            DIRECT: begin
                dout_d = oneHot(din);
                idx_d  = din;
            end

            SCAN: begin
                if (state_q != SCAN) begin
                    // Fresh entry always restarts at index 0 with a wrap
                    // pulse and no leading blank; this first cycle counts
                    // as dwell cycle 1.
                    dout_d = ONE_N;
                    idx_d  = '0;
                    wrap_d = 1'b1;
                    cnt_d  = CNT_ONE;
                end else begin
`ifdef DECODER_SCAN_BLANK_EN
                    if (blank_q) begin
                        // Blank cycle over: drive the index that dout_idx
                        // has been showing during the blank.
                        dout_d = oneHot(idx_q);
                        idx_d  = idx_q;
                        wrap_d = (idx_q == '0);
                        cnt_d  = CNT_ONE;
                    end else if (cnt_q >= DWELL_C) begin
                        // Dwell complete: break before make. The index
                        // advances now so dout_idx previews it.
                        dout_d  = '0;
                        idx_d   = idx_q + IDX_ONE;
                        blank_d = 1'b1;
                        cnt_d   = cnt_q;
                    end else begin
                        dout_d = dout_q;
                        idx_d  = idx_q;
                        cnt_d  = cnt_q + CNT_ONE;
                    end
`else
                    if (cnt_q >= DWELL_C) begin
                        // Dwell complete: modular SEL_W-bit increment, so
                        // N-1 rolls over to 0 and marks a new period.
                        idx_d  = idx_q + IDX_ONE;
                        dout_d = oneHot(idx_q + IDX_ONE);
                        wrap_d = ((idx_q + IDX_ONE) == '0);
                        cnt_d  = CNT_ONE;
                    end else begin
                        dout_d = dout_q;
                        idx_d  = idx_q;
                        cnt_d  = cnt_q + CNT_ONE;
                    end
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset is synchronous and overrides the
    // enable and mode inputs, so a reset edge always lands in IDLE with
    // every output cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dout_q  <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef DECODER_SCAN_BLANK_EN
            blank_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
`ifdef DECODER_SCAN_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign dout_idx  = idx_q;
    assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// ---------------------------------------------------------------------------
// tb_decoder_scan_n
//
// Scoreboard bench for decoder_scan_n. Four instances cover the parameter
// sets of interest:
//   id 0: SEL_W=2 DWELL=3   reset, direct sweep, full scan sequence
//   id 1: SEL_W=2 DWELL=4   enable drop mid-scan, reset priority
//   id 2: SEL_W=1 DWELL=2   short scan (blanking when the macro is defined)
//   id 3: SEL_W=3 DWELL=1   direct to scan mode switch
// The driver pushes the expected post-edge outputs as it applies each
// vector; a separate monitor pops and compares one entry per cycle.
// ---------------------------------------------------------------------------
module tb_decoder_scan_n;

`ifdef DECODER_SCAN_BLANK_EN
    localparam int BLANK = 1;
`else
    localparam int BLANK = 0;
`endif

    typedef struct {
        int          id;
        logic [63:0] dout;
        logic [7:0]  idx;
        logic        wrap;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    logic       clk = 1'b0;
    logic       rstA  [4];
    logic       enA   [4];
    logic       modeA [4];
    logic [7:0] dinA  [4];

    logic [3:0] dout0, dout1;
    logic [1:0] dout2;
    logic [7:0] dout3;
    logic [1:0] idx0, idx1;
    logic [0:0] idx2;
    logic [2:0] idx3;
    logic       wrap0, wrap1, wrap2, wrap3;

    always #5 clk = ~clk;

    decoder_scan_n #(.SEL_W(2), .DWELL(3)) u0 (
        .clk(clk), .rst(rstA[0]), .d_en(enA[0]), .d_mode(modeA[0]),
        .din(dinA[0][1:0]), .dout(dout0), .dout_idx(idx0), .scan_wrap(wrap0));

    decoder_scan_n #(.SEL_W(2), .DWELL(4)) u1 (
        .clk(clk), .rst(rstA[1]), .d_en(enA[1]), .d_mode(modeA[1]),
        .din(dinA[1][1:0]), .dout(dout1), .dout_idx(idx1), .scan_wrap(wrap1));

    decoder_scan_n #(.SEL_W(1), .DWELL(2)) u2 (
        .clk(clk), .rst(rstA[2]), .d_en(enA[2]), .d_mode(modeA[2]),
        .din(dinA[2][0:0]), .dout(dout2), .dout_idx(idx2), .scan_wrap(wrap2));

    decoder_scan_n #(.SEL_W(3), .DWELL(1)) u3 (
        .clk(clk), .rst(rstA[3]), .d_en(enA[3]), .d_mode(modeA[3]),
        .din(dinA[3][2:0]), .dout(dout3), .dout_idx(idx3), .scan_wrap(wrap3));

    // Compare one scoreboard entry against the addressed instance.
    task automatic checkOutput(input exp_t e);
        logic [63:0] actD;
        logic [7:0]  actI;
        logic        actW;
        case (e.id)
            0:       begin actD = 64'(dout0); actI = 8'(idx0); actW = wrap0; end
            1:       begin actD = 64'(dout1); actI = 8'(idx1); actW = wrap1; end
            2:       begin actD = 64'(dout2); actI = 8'(idx2); actW = wrap2; end
            default: begin actD = 64'(dout3); actI = 8'(idx3); actW = wrap3; end
        endcase
        checks++;
        if (actD !== e.dout || actI !== e.idx || actW !== e.wrap) begin
            fails++;
            $display("[TB] FAIL %s (dut %0d): got dout=%h idx=%0d wrap=%b, expected dout=%h idx=%0d wrap=%b",
                     e.name, e.id, actD, actI, actW, e.dout, e.idx, e.wrap);
        end
    endtask

    // Drive one cycle of inputs on an instance and record what it must show
    // after the next rising edge.
    task automatic applyStimulus(input int id, input logic r, input logic en,
                                 input logic md, input logic [7:0] d,
                                 input logic [63:0] eD, input logic [7:0] eI,
                                 input logic eW, input string nm);
        exp_t e;
        @(negedge clk);
        rstA[id]  = r;
        enA[id]   = en;
        modeA[id] = md;
        dinA[id]  = d;
        e.id   = id;
        e.dout = eD;
        e.idx  = eI;
        e.wrap = eW;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Reference scan position for cycle c (1 = entry cycle). Each slot is
    // DWELL driven cycles followed, when blanking, by one blank cycle that
    // previews the next index.
    task automatic scanExp(input int c, input int dwell, input int n,
                           output logic [63:0] eD, output logic [7:0] eI,
                           output logic eW);
        int p, q, k, r;
        p = dwell + BLANK;
        q = (c - 1) % (n * p);
        k = q / p;
        r = q % p;
        if (r < dwell) begin
            eD = 64'(1) << k;
            eI = 8'(k);
            eW = (q == 0);
        end else begin
            eD = '0;
            eI = 8'((k + 1) % n);
            eW = 1'b0;
        end
    endtask

    // Run `count` scan cycles on an instance starting at scan cycle startC,
    // wiggling din to show it is ignored.
    task automatic scanCycles(input int id, input int dwell, input int n,
                              input int startC, input int count, input string nm);
        logic [63:0] eD;
        logic [7:0]  eI;
        logic        eW;
        for (int c = startC; c < startC + count; c++) begin
            scanExp(c, dwell, n, eD, eI, eW);
            applyStimulus(id, 1'b0, 1'b1, 1'b1, 8'(c * 3 + 1), eD, eI, eW, nm);
        end
    endtask

    // Monitor: every output is valid each cycle, so pop one expectation per
    // cycle, sampled just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        int p;
        p = 0;
        for (int i = 0; i < 4; i++) begin
            rstA[i] = 1'b1; enA[i] = 1'b0; modeA[i] = 1'b0; dinA[i] = 8'd0;
        end

        // ---- id 0: reset, direct decode and sweep, full scan ----
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 8'd1, 64'h0, 8'd0, 1'b0, "reset0 c1");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 8'd0, 64'h0, 8'd0, 1'b0, "reset0 c2");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'd2, 64'h4, 8'd2, 1'b0, "direct din=2");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'd0, 64'h1, 8'd0, 1'b0, "sweep din=0");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'd1, 64'h2, 8'd1, 1'b0, "sweep din=1");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'd2, 64'h4, 8'd2, 1'b0, "sweep din=2");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'd3, 64'h8, 8'd3, 1'b0, "sweep din=3");
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 8'd3, 64'h0, 8'd0, 1'b0, "disable");
        scanCycles(0, 3, 4, 1, 15, "scan dwell3");
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 8'd3, 64'h0, 8'd0, 1'b0, "rst over direct");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 8'd1, 64'h2, 8'd1, 1'b0, "direct after rst");

        // ---- id 1: enable drop mid-scan, reset priority ----
        p = 4 + BLANK;
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 8'd0, 64'h0, 8'd0, 1'b0, "reset1");
        scanCycles(1, 4, 4, 1, 2 * p + 2, "scan to idx2");
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 8'd0, 64'h0, 8'd0, 1'b0, "en drop c1");
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 8'd0, 64'h0, 8'd0, 1'b0, "en drop c2");
        scanCycles(1, 4, 4, 1, 3 * p + 1, "rescan to idx3");
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 8'd0, 64'h0, 8'd0, 1'b0, "rst mid-scan");
        scanCycles(1, 4, 4, 1, 5, "scan after rst");

        // ---- id 2: SEL_W=1 DWELL=2 scan (break-before-make when enabled) ----
        applyStimulus(2, 1'b1, 1'b1, 1'b1, 8'd0, 64'h0, 8'd0, 1'b0, "reset2");
`ifdef DECODER_SCAN_BLANK_EN
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'd0, 64'h1, 8'd0, 1'b1, "blank c1");
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'd1, 64'h1, 8'd0, 1'b0, "blank c2");
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'd0, 64'h0, 8'd1, 1'b0, "blank c3");
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'd1, 64'h2, 8'd1, 1'b0, "blank c4");
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'd0, 64'h2, 8'd1, 1'b0, "blank c5");
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'd1, 64'h0, 8'd0, 1'b0, "blank c6");
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'd0, 64'h1, 8'd0, 1'b1, "blank c7");
`else
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'd0, 64'h1, 8'd0, 1'b1, "scan2 c1");
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'd1, 64'h1, 8'd0, 1'b0, "scan2 c2");
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'd0, 64'h2, 8'd1, 1'b0, "scan2 c3");
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'd1, 64'h2, 8'd1, 1'b0, "scan2 c4");
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'd0, 64'h1, 8'd0, 1'b1, "scan2 c5");
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'd1, 64'h1, 8'd0, 1'b0, "scan2 c6");
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 8'd0, 64'h2, 8'd1, 1'b0, "scan2 c7");
`endif

        // ---- id 3: SEL_W=3 DWELL=1, direct then scan ----
        applyStimulus(3, 1'b1, 1'b0, 1'b0, 8'd0, 64'h0, 8'd0, 1'b0, "reset3");
        applyStimulus(3, 1'b0, 1'b1, 1'b0, 8'd5, 64'h20, 8'd5, 1'b0, "direct din=5");
        scanCycles(3, 1, 8, 1, 18, "scan dwell1");
        applyStimulus(3, 1'b0, 1'b1, 1'b0, 8'd7, 64'h80, 8'd7, 1'b0, "back to direct");

        // Let the monitor drain the scoreboard.
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
